// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus fabric: FSM encoding,
// error-type codes and the default SoC memory map.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic ERR_TYPE_DECODE  = 1'b0;
    localparam logic ERR_TYPE_TIMEOUT = 1'b1;

    // Default SoC memory map: SRAM at the bottom, peripherals on single address bits.
    localparam logic [31:0] SRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] SRAM_MASK = 32'hFFF0_0000;
    localparam logic [31:0] GPIO_BASE = 32'h0010_0000;
    localparam logic [31:0] GPIO_MASK = 32'hFFF0_0000;
    localparam logic [31:0] UART_BASE = 32'h0020_0000;
    localparam logic [31:0] UART_MASK = 32'hFFF0_0000;
    localparam logic [31:0] QSPI_BASE = 32'h0040_0000;
    localparam logic [31:0] QSPI_MASK = 32'hFFF0_0000;
    localparam logic [31:0] BOOT_BASE = 32'h0080_0000;
    localparam logic [31:0] BOOT_MASK = 32'hFFF0_0000;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Bus bundle between the CPU native memory port, the fabric and the slaves.
// Handshake: a request is live while valid is high; the addressed side
// completes it by raising ready for exactly the cycle in which rdata is valid.
// The master holds address/data stable until ready, and may drop valid early
// to abandon the request, in which case no response is produced.
interface mem_bus_fabric_if #(
    parameter int NUM_SLAVES = 5
);
    logic                    m_valid;
    logic [31:0]             m_addr;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_ready;
    logic [31:0]             m_rdata;
    logic [NUM_SLAVES-1:0]   s_valid;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [NUM_SLAVES*32-1:0] s_rdata;

    modport master (output m_valid, m_addr, m_wdata, m_wstrb, input m_ready, m_rdata);
    modport slave  (input s_valid, s_addr, s_wdata, s_wstrb, output s_ready, s_rdata);
    modport fabric (input m_valid, m_addr, m_wdata, m_wstrb, output m_ready, m_rdata,
                    output s_valid, s_addr, s_wdata, s_wstrb, input s_ready, s_rdata);
endinterface

// File: rtl/mem_bus_decode.sv
// Priority address decoder: one-hot match of the lowest-index slave whose
// masked base equals the masked address, plus a hit flag.
module mem_bus_decode #(
    parameter int                        NUM_SLAVES = 5,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = {NUM_SLAVES{32'hFFF0_0000}}
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] match,
    output logic                  hit
);

    // Scan upward; the first match blocks all higher indices.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                match[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Memory bus fabric: decodes the CPU request to one slave, guards it with a
// timeout watchdog and answers decode misses / timeouts with an error beat.
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFF0_0000}},
    parameter int                        TIMEOUT_CYCLES = 1023,
    parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic            mem_clk,
    input  logic            rst,
    mem_bus_fabric_if.fabric bus,
    input  logic            err_clr,
    output logic            bus_err,
    output logic            err_type,
    output logic [31:0]     err_addr,
    output logic [7:0]      err_count,
    output state_t          dbg_state
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [15:0]           timer_q, timer_d;
    logic                  pend_type_q, pend_type_d;
    logic                  bus_err_q, bus_err_d;
    logic                  err_type_q, err_type_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic [NUM_SLAVES-1:0] dec_match;
    logic                  dec_hit;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic [NUM_SLAVES-1:0] s_valid_c;
    logic                  m_ready_c;
    logic [31:0]           m_rdata_c;

    mem_bus_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr  (bus.m_addr),
        .match (dec_match),
        .hit   (dec_hit)
    );

    // Pick ready/rdata of the latched slave only; other slaves are ignored.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = bus.s_rdata[32*i +: 32];
        end
        sel_ready = |(bus.s_ready & sel_q);
    end

    // Next-state logic and bus-facing outputs of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        pend_type_d = pend_type_q;
        s_valid_c   = '0;
        m_ready_c   = 1'b0;
        m_rdata_c   = '0;
        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    if (dec_hit) begin
                        sel_d   = dec_match;
                        timer_d = '0;
                        state_d = ACTIVE;
                    end else begin
                        pend_type_d = ERR_TYPE_DECODE;
                        state_d     = ERR;
                    end
                end
            end
            ACTIVE: begin
                s_valid_c = sel_q & {NUM_SLAVES{bus.m_valid}};
                m_ready_c = sel_ready;
                m_rdata_c = sel_ready ? sel_rdata : 32'h0;
                // A ready on the last allowed cycle still completes normally.
                if (sel_ready) begin
                    state_d = IDLE;
                end else if (!bus.m_valid) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    pend_type_d = ERR_TYPE_TIMEOUT;
                    state_d     = ERR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ERR: begin
                m_ready_c = 1'b1;
                m_rdata_c = ERR_RDATA;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error status; a new error beats a simultaneous clear.
    always_comb begin
        bus_err_d   = bus_err_q;
        err_type_d  = err_type_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (state_q == ERR) begin
            bus_err_d   = 1'b1;
            err_type_d  = pend_type_q;
            err_addr_d  = bus.m_addr;
            err_count_d = err_clr ? 8'd1 : sat_inc8(err_count_q);
        end else if (err_clr) begin
            bus_err_d   = 1'b0;
            err_type_d  = 1'b0;
            err_addr_d  = '0;
            err_count_d = '0;
        end
    end

    // State, selection, watchdog and status registers.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            pend_type_q <= 1'b0;
            bus_err_q   <= 1'b0;
            err_type_q  <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            pend_type_q <= pend_type_d;
            bus_err_q   <= bus_err_d;
            err_type_q  <= err_type_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.s_valid = s_valid_c;
    assign bus.m_ready = m_ready_c;
    assign bus.m_rdata = m_rdata_c;
    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;

    assign bus_err   = bus_err_q;
    assign err_type  = err_type_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Bench for mem_bus_fabric: directed scenarios plus a random back-to-back
// run, with read data checked against an expected-response queue.
module tb_mem_bus_fabric;
  import mem_bus_pkg::*;

  localparam int NS = 5;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASE = {32'h0020_0000, 32'h0010_0000, 32'h0040_0000,
                                       32'h0040_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFFC0_0000,
                                       32'hFFC0_0000, 32'hFFF0_0000};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        err_clr;
  logic        bus_err;
  logic        err_type;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
  state_t      dbg_state;

  mem_bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

  mem_bus_fabric #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)
  ) dut (
    .mem_clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr), .bus_err(bus_err),
    .err_type(err_type), .err_addr(err_addr), .err_count(err_count), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int n_cmp = 0;
  int n_err = 0;

  // driver observations
  logic [NS-1:0] idle_sv, sv_or;
  int            sv_cycles, ready_k;
  logic          got;
  logic [31:0]   got_rdata;

  // Driver: called and returns at posedge+1. Raises m_valid this cycle, plays
  // slave slv (ready held once it has seen s_valid for lat cycles, lat<0 never),
  // optionally pulses err_clr in loop cycle clr_at, then drops m_valid.
  task automatic drive_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int slv,
                           input int lat, input logic [31:0] rdata, input int budget,
                           input int clr_at, input bit noise);
    logic [31:0] r;
    bus.m_valid = 1'b1; bus.m_addr = addr; bus.m_wdata = $urandom; bus.m_wstrb = wstrb;
    bus.s_ready = '0; err_clr = 1'b0;
    #2;
    idle_sv = bus.s_valid; sv_or = '0; sv_cycles = 0; ready_k = -1; got = 1'b0; got_rdata = '0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      err_clr = (k == clr_at);
      r = $urandom;
      bus.s_ready = noise ? r[NS-1:0] : '0;
      for (int j = 0; j < NS; j++) bus.s_rdata[32*j +: 32] = noise ? $urandom : 32'h0;
      if (slv >= 0 && slv < NS) begin
        bus.s_ready[slv] = (lat >= 0 && sv_cycles >= lat);
        bus.s_rdata[32*slv +: 32] = rdata;
      end
      #2;
      if (bus.s_valid != '0) sv_cycles++;
      sv_or |= bus.s_valid;
      if (bus.m_ready) begin
        got = 1'b1; ready_k = k; got_rdata = bus.m_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b0; bus.s_ready = '0; bus.s_rdata = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL rst_m_ready: got %b want 0", bus.m_ready); end
    n_cmp++; if (bus.s_valid !== '0) begin n_err++; $display("FAIL rst_s_valid: got %b want 0", bus.s_valid); end
    n_cmp++; if (bus.m_rdata !== 32'h0) begin n_err++; $display("FAIL rst_m_rdata: got %h want 0", bus.m_rdata); end
    n_cmp++; if ({bus_err, err_type, err_addr, err_count} !== 42'h0) begin n_err++;
      $display("FAIL rst_status: got err=%b type=%b addr=%h cnt=%0d want all 0", bus_err, err_type, err_addr, err_count); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode_hit();
    exp_q.push_back(32'h1234_5678);
    drive_txn(32'h0000_0010, 4'h0, 0, 2, 32'h1234_5678, 20, -1, 1'b1);
    n_cmp++; if (idle_sv !== '0) begin n_err++; $display("FAIL hit_decode_cycle_sv: got %b want 0", idle_sv); end
    n_cmp++; if (sv_or !== 5'b00001) begin n_err++; $display("FAIL hit_sv: got %b want 00001", sv_or); end
    n_cmp++; if (ready_k !== 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", ready_k); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL hit_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL hit_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_priority();
    // s_ready only from the shadowed slave 2: must not complete
    drive_txn(32'h0040_0004, 4'h0, 2, 0, 32'hAAAA_0002, 6, -1, 1'b0);
    n_cmp++; if (sv_or !== 5'b00010) begin n_err++; $display("FAIL prio_sv: got %b want 00010", sv_or); end
    n_cmp++; if (got !== 1'b0) begin n_err++; $display("FAIL prio_unselected_ready: got m_ready=%b want 0", got); end
    @(posedge clk); #1;
    exp_q.push_back(32'hAAAA_0001);
    drive_txn(32'h0040_0004, 4'hF, 1, 1, 32'hAAAA_0001, 20, -1, 1'b0);
    n_cmp++; if (sv_or !== 5'b00010) begin n_err++; $display("FAIL prio_sv2: got %b want 00010", sv_or); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL prio_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
  endtask

  task automatic test_decode_miss();
    exp_q.push_back(ERRD);
    drive_txn(32'h8000_0000, 4'h0, -1, -1, 32'h0, 10, -1, 1'b1);
    n_cmp++; if (ready_k !== 0) begin n_err++; $display("FAIL miss_latency: got %0d want 0", ready_k); end
    n_cmp++; if (sv_or !== '0) begin n_err++; $display("FAIL miss_sv: got %b want 0", sv_or); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL miss_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
    n_cmp++; if ({bus_err, err_type, err_addr, err_count} !== {1'b1, 1'b0, 32'h8000_0000, 8'd1}) begin n_err++;
      $display("FAIL miss_status: got err=%b type=%b addr=%h cnt=%0d want 1 0 80000000 1", bus_err, err_type, err_addr, err_count); end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    n_cmp++; if ({bus_err, err_type, err_addr, err_count} !== 42'h0) begin n_err++;
      $display("FAIL clr_status: got err=%b type=%b addr=%h cnt=%0d want all 0", bus_err, err_type, err_addr, err_count); end
  endtask

  task automatic test_timeout();
    exp_q.push_back(ERRD);
    drive_txn(32'h0000_0100, 4'h3, 0, -1, 32'h0, 20, -1, 1'b1);
    n_cmp++; if (sv_cycles !== TO) begin n_err++; $display("FAIL to_sv_cycles: got %0d want %0d", sv_cycles, TO); end
    n_cmp++; if (ready_k !== TO) begin n_err++; $display("FAIL to_latency: got %0d want %0d", ready_k, TO); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL to_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
    n_cmp++; if ({bus_err, err_type, err_addr, err_count} !== {1'b1, 1'b1, 32'h0000_0100, 8'd1}) begin n_err++;
      $display("FAIL to_status: got err=%b type=%b addr=%h cnt=%0d want 1 1 00000100 1", bus_err, err_type, err_addr, err_count); end
    // ready on the last allowed cycle wins over the timeout
    exp_q.push_back(32'h0BAD_F00D);
    drive_txn(32'h0000_0200, 4'h0, 0, TO - 1, 32'h0BAD_F00D, 20, -1, 1'b1);
    n_cmp++; if (ready_k !== TO - 1) begin n_err++; $display("FAIL to_edge_latency: got %0d want %0d", ready_k, TO - 1); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL to_edge_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
    n_cmp++; if (err_count !== 8'd1 || err_addr !== 32'h0000_0100) begin n_err++;
      $display("FAIL to_edge_no_err: got cnt=%0d addr=%h want 1 00000100", err_count, err_addr); end
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(ERRD);
      drive_txn(32'h8000_0000 | 32'(i * 4), 4'h0, -1, -1, 32'h0, 10, -1, 1'b0);
      exp_v = exp_q.pop_front();
      if (!got || got_rdata !== exp_v) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL sat_responses: got %0d bad error beats want 0", bad); end
    n_cmp++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", err_count); end
    exp_q.push_back(ERRD);
    drive_txn(32'h9000_0010, 4'h0, -1, -1, 32'h0, 10, 0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL coll_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
    n_cmp++; if ({bus_err, err_type, err_addr, err_count} !== {1'b1, 1'b0, 32'h9000_0010, 8'd1}) begin n_err++;
      $display("FAIL coll_status: got err=%b type=%b addr=%h cnt=%0d want 1 0 90000010 1", bus_err, err_type, err_addr, err_count); end
  endtask

  task automatic test_abort();
    drive_txn(32'h0010_0020, 4'h0, 3, -1, 32'h0, 3, -1, 1'b0);
    n_cmp++; if (got !== 1'b0 || sv_cycles !== 3 || sv_or !== 5'b01000) begin n_err++;
      $display("FAIL abort_active: got ready=%b sv_cycles=%0d sv=%b want 0 3 01000", got, sv_cycles, sv_or); end
    #2;
    n_cmp++; if (bus.m_ready !== 1'b0 || bus.s_valid !== '0) begin n_err++;
      $display("FAIL abort_drop: got m_ready=%b s_valid=%b want 0 0", bus.m_ready, bus.s_valid); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_state !== IDLE || err_count !== 8'd1) begin n_err++;
      $display("FAIL abort_idle: got state=%0d cnt=%0d want IDLE 1", dbg_state, err_count); end
  endtask

  task automatic test_reset_mid();
    bus.m_valid = 1'b1; bus.m_addr = 32'h0010_0004; bus.m_wstrb = 4'h0; bus.s_ready = '0;
    @(posedge clk); #1;
    n_cmp++; if (bus.s_valid !== 5'b01000) begin n_err++; $display("FAIL rmid_sv: got %b want 01000", bus.s_valid); end
    bus.s_ready = 5'b01000; bus.s_rdata[32*3 +: 32] = 32'h5555_AAAA;
    #1;
    n_cmp++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready_before: got %b want 1", bus.m_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.s_valid !== '0 || bus.m_ready !== 1'b0 || dbg_state !== IDLE) begin n_err++;
      $display("FAIL rmid_async: got s_valid=%b m_ready=%b state=%0d want 0 0 IDLE", bus.s_valid, bus.m_ready, dbg_state); end
    n_cmp++; if (bus_err !== 1'b0 || err_count !== 8'd0) begin n_err++;
      $display("FAIL rmid_status: got err=%b cnt=%0d want 0 0", bus_err, err_count); end
    bus.m_valid = 1'b0; bus.s_ready = '0; bus.s_rdata = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h7777_0004);
    drive_txn(32'h0020_0008, 4'h1, 4, 1, 32'h7777_0004, 20, -1, 1'b1);
    n_cmp++; if (sv_or !== 5'b10000 || ready_k !== 1) begin n_err++;
      $display("FAIL rmid_next: got sv=%b lat=%0d want 10000 1", sv_or, ready_k); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL rmid_rdata: got %h (ready=%b) want %h", got_rdata, got, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hit_base [4];
    int          hit_idx [4];
    int          exp_cnt = 0;
    logic [31:0] last_miss = 32'h0;
    logic [31:0] addr, rd;
    int          kind, lat;
    hit_base = '{32'h0000_0000, 32'h0040_0000, 32'h0010_0000, 32'h0020_0000};
    hit_idx  = '{0, 1, 3, 4};
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 4);
      addr = 32'($urandom_range(0, 32'h000F_FFFF)) & 32'hFFFF_FFFC;
      if (kind == 4) begin
        addr = addr | 32'hC000_0000;
        exp_q.push_back(ERRD);
        drive_txn(addr, 4'($urandom_range(0, 15)), -1, -1, 32'h0, 10, -1, 1'b1);
        exp_cnt++;
        last_miss = addr;
        n_cmp++; if (ready_k !== 0 || sv_or !== '0) begin n_err++;
          $display("FAIL b2b_miss_shape[%0d]: got lat=%0d sv=%b want 0 0", t, ready_k, sv_or); end
      end else begin
        addr = addr | hit_base[kind];
        lat  = $urandom_range(0, 4);
        rd   = $urandom;
        exp_q.push_back(rd);
        drive_txn(addr, 4'($urandom_range(0, 15)), hit_idx[kind], lat, rd, 20, -1, 1'b1);
        n_cmp++; if (ready_k !== lat || sv_or !== NS'(1 << hit_idx[kind]) || sv_cycles !== lat + 1) begin n_err++;
          $display("FAIL b2b_hit_shape[%0d]: got lat=%0d sv=%b cyc=%0d want %0d %b %0d", t, ready_k, sv_or, sv_cycles, lat, NS'(1 << hit_idx[kind]), lat + 1); end
      end
      exp_v = exp_q.pop_front();
      n_cmp++; if (!got || got_rdata !== exp_v) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h (ready=%b) want %h", t, got_rdata, got, exp_v); end
    end
    n_cmp++; if (err_count !== 8'(exp_cnt) || (exp_cnt > 0 && err_addr !== last_miss)) begin n_err++;
      $display("FAIL b2b_status: got cnt=%0d addr=%h want %0d %h", err_count, err_addr, exp_cnt, last_miss); end
  endtask

  initial begin
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.s_ready = '0; bus.s_rdata = '0; err_clr = 1'b0;
    test_reset();
    test_decode_hit();
    test_priority();
    test_decode_miss();
    test_err_clr();
    test_timeout();
    test_saturation();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_fabric.md
Name: mem_bus_fabric

Overview:
- Parametrised replacement for the hand-wired valid/ready/rdata OR-mux that joins the picorv32 native memory bus to SoC peripherals (SRAM, GPIO, UART, QSPI, BOOT and future slaves).
- Adds a table-driven address decoder and a registered slave select.
- Adds a per-transaction timeout watchdog and a decode-miss/timeout error response, so a missing or hung slave cannot stall the CPU.
- Adds a sticky error status.
- Sits between the cpu instance and all memory-mapped slaves in the chip top.

Parameters:
- NUM_SLAVES, 5, number of slave channels (1..16).
- SLAVE_BASE, {5{32'h0}}, packed NUM_SLAVES*32 base addresses; slave i occupies bits [32*i+31:32*i].
- SLAVE_MASK, {5{32'hFFF0_0000}}, packed NUM_SLAVES*32 masks; slave i matches when (m_addr & MASK_i) == BASE_i.
- TIMEOUT_CYCLES, 1023, ACTIVE cycles allowed before timeout (1..65535).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response.

Ports:
- mem_clk, input, 1: fabric clock.
- rst, input, 1: asynchronous active-high reset.
- m_valid, input, 1: master request valid.
- m_addr, input, 32: master byte address.
- m_wdata, input, 32: master write data.
- m_wstrb, input, 4: byte strobes; 0 means read.
- m_ready, output, 1: transaction complete.
- m_rdata, output, 32: read data, valid while m_ready.
- s_valid, output, NUM_SLAVES: one-hot slave request.
- s_addr, output, 32: m_addr passthrough.
- s_wdata, output, 32: m_wdata passthrough.
- s_wstrb, output, 4: m_wstrb passthrough.
- s_ready, input, NUM_SLAVES: slave completion.
- s_rdata, input, NUM_SLAVES*32: packed slave read data.
- err_clr, input, 1: single-cycle clear of the error status.
- bus_err, output, 1: sticky error flag.
- err_type, output, 1: 0 = decode miss, 1 = timeout.
- err_addr, output, 32: address of the latest error.
- err_count, output, 8: saturating error count.

Behaviour:
- Reset: state=IDLE, sel=0, timer=0, s_valid=0, m_ready=0, m_rdata=0, bus_err=0, err_type=0, err_addr=0, err_count=0.
- FSM states: IDLE, ACTIVE, ERR.
- IDLE:
  - m_valid=1 triggers a decode of m_addr against all slaves; the lowest index match wins.
  - Match: latch one-hot sel, clear timer, go ACTIVE.
  - No match: go ERR with err_type_next=0.
  - s_valid=0 in IDLE, so every transaction gains 1 cycle of decode latency.
- ACTIVE:
  - s_valid = sel & {NUM_SLAVES{m_valid}}.
  - m_ready = |(s_ready & sel), combinational. m_rdata = s_rdata of the selected slave while m_ready=1, else 0.
  - s_ready/s_rdata from unselected slaves are ignored.
  - Exit to IDLE when m_ready=1.
  - Exit to IDLE with no response and no error when m_valid drops (abort).
  - timer increments every cycle. When timer==TIMEOUT_CYCLES-1 and the slave is not ready: force s_valid=0 next cycle, go ERR with err_type_next=1.
  - If s_ready arrives on the timeout cycle, the ready wins and no error is recorded.
- ERR (exactly 1 cycle):
  - m_ready=1, m_rdata=ERR_RDATA, s_valid=0.
  - Update status: bus_err=1, err_type, err_addr=m_addr, err_count+1 saturating at 255.
  - Next state IDLE.
- Status:
  - err_clr=1 zeroes bus_err, err_type, err_addr and err_count.
  - An ERR-state update in the same cycle as err_clr takes priority: status then reflects only the new error, with count=1.
- Passthrough signals s_addr/s_wdata/s_wstrb are purely combinational.
- Writes and reads are handled identically; the fabric never inspects m_wstrb.
- Asynchronous reset mid-transaction immediately drops s_valid and m_ready. A slave left mid-operation must tolerate s_valid falling.
- Back-to-back transactions: after m_ready the FSM is in IDLE on the next cycle, so the minimum transaction is 2 cycles plus slave latency.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, ERR=2'd2);
  - ERR_TYPE_DECODE / ERR_TYPE_TIMEOUT constants;
  - default SoC memory-map constants (SRAM 0x0000_0000 with mask 0xFFF0_0000; GPIO bit 20; UART bit 21; QSPI bit 22; BOOT bit 23).
- One natural sub-module: mem_bus_decode, combinational priority decoder producing one-hot match and a hit flag from m_addr, SLAVE_BASE and SLAVE_MASK.

Test Plan:
1. Decode hit, slave ready after 2 cycles:
   - Stimulus: read m_addr=0x0000_0010; slave0 s_ready 2 cycles after s_valid rises with s_rdata=0x1234_5678.
   - Response: s_valid=5'b00001 one cycle after m_valid; m_ready when slave ready; m_rdata=0x1234_5678; bus_err=0.
2. Overlapping map, priority:
   - Stimulus: set BASE1=BASE2=0x0040_0000, both masks 0xFFC0_0000; access 0x0040_0004.
   - Response: only s_valid[1] asserts; s_ready[2]=1 alone never produces m_ready.
3. Decode miss:
   - Stimulus: access 0x8000_0000 with no matching slave.
   - Response: m_ready 1 cycle after m_valid; m_rdata=0xDEAD_BEEF; bus_err=1, err_type=0, err_addr=0x8000_0000, err_count=1; no s_valid.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=8; slave never ready.
   - Response: s_valid high for exactly 8 cycles, then ERR with m_ready=1, err_type=1, err_count increments. Repeat with s_ready on the 8th cycle: normal completion, no error.
5. err_clr collision and saturation:
   - Stimulus: 300 decode misses.
   - Response: err_count=255 after saturation. Then assert err_clr in the same cycle as the next ERR: bus_err=1, err_count=1.
6. Abort and reset mid-operation:
   - Stimulus: drop m_valid during ACTIVE, then assert rst during ACTIVE.
   - Response: abort returns to IDLE with no m_ready and no error; rst immediately drops s_valid=0 and m_ready=0, and the next transaction decodes normally.
